// File: rtl/contador_decadico_crescente_2dig.sv
// Synchronous up-counting BCD decade counter, DIGITS cascaded digits.
// Synchronous load, count enable, combinational terminal count, registered wrap pulse.
module contador_decadico_crescente_2dig #(
    parameter int                    DIGITS    = 2,
    parameter logic [4*DIGITS-1:0]   RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  preset,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  wrap
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]      r_count;
    logic              r_wrap;
    logic [W-1:0]      w_next;
    logic [DIGITS:0]   w_carry;

    // Carry into digit k: enable and every lower digit exactly 9 (non-BCD is not 9)
    always_comb begin
        w_carry    = '0;
        w_carry[0] = en;
        for (int k = 0; k < DIGITS; k++) begin
            w_carry[k+1] = w_carry[k] & (r_count[4*k +: 4] == 4'd9);
        end
    end

    // A digit at 9 or above (non-BCD) returns to 0; only 9 propagates a carry
    always_comb begin
        w_next = r_count;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_carry[k]) begin
                if (r_count[4*k +: 4] >= 4'd9) begin
                    w_next[4*k +: 4] = 4'd0;
                end else begin
                    w_next[4*k +: 4] = r_count[4*k +: 4] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            r_count <= RESET_VAL;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_count <= load_val;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_wrap  <= w_carry[DIGITS];
        end
    end

    assign count = r_count;
    assign tc    = w_carry[DIGITS];
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_contador_decadico_crescente_2dig.sv
// Bench for the 2-digit BCD up counter: directed scenarios plus
// randomized traffic checked against a decimal-arithmetic reference model.
module tb_contador_decadico_crescente_2dig;

    logic       clk;
    logic       preset;
    logic       en;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc;
    logic       wrap;

    int total;
    int bad;

    int m_d0;
    int m_d1;
    bit m_wrap;
    bit tc_seen;
    bit exp_tc;

    contador_decadico_crescente_2dig #(
        .DIGITS    (2),
        .RESET_VAL (8'h00)
    ) dut (
        .clk      (clk),
        .preset   (preset),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] m_count();
        logic [3:0] a;
        logic [3:0] b;
        a = 4'(m_d1);
        b = 4'(m_d0);
        return {a, b};
    endfunction

    // Reference: decimal value arithmetic for BCD counts, digit rules otherwise
    task automatic model_step(input bit e, input bit l, input logic [7:0] lv);
        int v;
        bit c;
        if (l) begin
            m_d0   = int'(lv[3:0]);
            m_d1   = int'(lv[7:4]);
            m_wrap = 1'b0;
        end else if (e) begin
            if (m_d0 <= 9 && m_d1 <= 9) begin
                v      = m_d1 * 10 + m_d0;
                m_wrap = (v == 99);
                v      = (v + 1) % 100;
                m_d1   = v / 10;
                m_d0   = v % 10;
            end else begin
                c      = (m_d0 == 9);
                m_d0   = (m_d0 >= 9) ? 0 : m_d0 + 1;
                if (c) m_d1 = (m_d1 >= 9) ? 0 : m_d1 + 1;
                m_wrap = 1'b0;
            end
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    task automatic cyc(input bit e, input bit l, input logic [7:0] lv);
        en       = e;
        load     = l;
        load_val = lv;
        #1;
        tc_seen = tc;
        exp_tc  = e && m_d0 == 9 && m_d1 == 9;
        model_step(e, l, lv);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        en       = 1'b1;
        load     = 1'b0;
        load_val = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (count !== 8'h00 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: count=%h wrap=%b, required 00/0", count, wrap);
        end
        en = 1'b0;
        @(negedge clk);
        preset = 1'b0;
        m_d0   = 0;
        m_d1   = 0;
        m_wrap = 1'b0;
    endtask

    task automatic test_count12();
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0, 8'h00);
            total++;
            if (count !== m_count() || wrap !== m_wrap) begin
                bad++;
                $display("FAIL count12[%0d]: count=%h wrap=%b, required %h/%b",
                         i, count, wrap, m_count(), m_wrap);
            end
        end
        total++;
        if (count !== 8'h12) begin
            bad++;
            $display("FAIL count12_end: count=%h, required 12", count);
        end
    endtask

    task automatic test_rollover();
        cyc(1'b0, 1'b1, 8'h97);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        total++;
        if (count !== 8'h99) begin
            bad++;
            $display("FAIL roll_99: count=%h, required 99", count);
        end
        cyc(1'b1, 1'b0, 8'h00);
        total++;
        if (tc_seen !== 1'b1) begin
            bad++;
            $display("FAIL roll_tc: tc=%b, required 1", tc_seen);
        end
        total++;
        if (count !== 8'h00 || wrap !== 1'b1) begin
            bad++;
            $display("FAIL roll_wrap: count=%h wrap=%b, required 00/1", count, wrap);
        end
        cyc(1'b0, 1'b0, 8'h00);
        total++;
        if (count !== 8'h00 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL roll_after: count=%h wrap=%b, required 00/0", count, wrap);
        end
        total++;
        if (tc_seen !== 1'b0) begin
            bad++;
            $display("FAIL tc_en0: tc=%b, required 0", tc_seen);
        end
    endtask

    task automatic test_load_priority();
        cyc(1'b1, 1'b1, 8'h42);
        total++;
        if (count !== 8'h42 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL load_prio: count=%h wrap=%b, required 42/0", count, wrap);
        end
        cyc(1'b1, 1'b1, 8'h99);
        cyc(1'b1, 1'b1, 8'h00);
        total++;
        if (count !== 8'h00 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL load_99_to_00: count=%h wrap=%b, required 00/0", count, wrap);
        end
    endtask

    task automatic test_nonbcd();
        cyc(1'b0, 1'b1, 8'h0C);
        cyc(1'b1, 1'b0, 8'h00);
        total++;
        if (count !== 8'h00) begin
            bad++;
            $display("FAIL nonbcd_fix: count=%h, required 00", count);
        end
        cyc(1'b1, 1'b0, 8'h00);
        total++;
        if (count !== 8'h01) begin
            bad++;
            $display("FAIL nonbcd_next: count=%h, required 01", count);
        end
        cyc(1'b0, 1'b1, 8'hE9);
        cyc(1'b1, 1'b0, 8'h00);
        total++;
        if (count !== 8'h00 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL nonbcd_top: count=%h wrap=%b, required 00/0", count, wrap);
        end
    endtask

    task automatic test_preset_mid();
        cyc(1'b0, 1'b1, 8'h55);
        cyc(1'b1, 1'b0, 8'h00);
        en = 1'b1;
        #2;
        preset = 1'b1;
        #1;
        total++;
        if (count !== 8'h00) begin
            bad++;
            $display("FAIL preset_async: count=%h, required 00", count);
        end
        repeat (2) @(posedge clk);
        en = 1'b0;
        @(negedge clk);
        preset = 1'b0;
        m_d0   = 0;
        m_d1   = 0;
        m_wrap = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        total++;
        if (count !== 8'h00) begin
            bad++;
            $display("FAIL preset_hold: count=%h, required 00", count);
        end
        cyc(1'b0, 1'b1, 8'h99);
        cyc(1'b1, 1'b0, 8'h00);
        #2;
        preset = 1'b1;
        #1;
        total++;
        if (wrap !== 1'b0 || count !== 8'h00) begin
            bad++;
            $display("FAIL preset_wrap_clr: count=%h wrap=%b, required 00/0", count, wrap);
        end
        en = 1'b0;
        @(negedge clk);
        preset = 1'b0;
        m_d0   = 0;
        m_d1   = 0;
        m_wrap = 1'b0;
    endtask

    task automatic test_random();
        bit         e;
        bit         l;
        logic [7:0] lv;
        for (int i = 0; i < 500; i++) begin
            e = ($urandom % 5) != 0;
            l = ($urandom % 12) == 0;
            if ($urandom % 4 == 0) begin
                lv = 8'($urandom);
            end else begin
                lv = {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
            end
            if ($urandom % 3 == 0) lv[7:4] = 4'd9;
            cyc(e, l, lv);
            total++;
            if (count !== m_count() || wrap !== m_wrap || tc_seen !== exp_tc) begin
                bad++;
                $display("FAIL rand[%0d]: count=%h wrap=%b tc=%b, required %h/%b/%b",
                         i, count, wrap, tc_seen, m_count(), m_wrap, exp_tc);
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        preset   = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        m_d0     = 0;
        m_d1     = 0;
        m_wrap   = 1'b0;
        test_reset();
        test_count12();
        test_rollover();
        test_load_priority();
        test_nonbcd();
        test_preset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
